pulse_evt_collector: RTL and testbench

// - Downstream consumer of the narrow-pulse synchroniser output (sync_pulse, already in clk domain).
// - Turns each stretched sync_pulse into exactly one event stamped with a free-running timestamp.
// - Buffers events in a small FIFO; software/control logic drains them via a valid/ready handshake.
// - Flags lost events with a sticky overflow bit.

---
 rtl/pulse_evt_if.sv | 45 ++++
 rtl/pulse_evt_collector.sv | 122 ++++++++++++
 tb/tb_pulse_evt_collector.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_evt_if.sv
// Event-collector bus: raw pulse input, drain handshake and loss status.
//   master : the collector (drives evt_valid, evt_ts, evt_level, ovf[, drop_cnt])
//   slave  : the pulse source / consumer side (drives sync_pulse, evt_ready, ovf_clr)
// Optional PULSE_EVT_DROP_CNT_EN adds the 8-bit drop_cnt signal.
interface pulse_evt_if #(
    parameter int unsigned TS_W = 16,
    parameter int unsigned AW   = 3
);
    logic            sync_pulse;
    logic            evt_ready;
    logic            ovf_clr;
    logic            evt_valid;
    logic [TS_W-1:0] evt_ts;
    logic [AW:0]     evt_level;
    logic            ovf;
`ifdef PULSE_EVT_DROP_CNT_EN
    logic [7:0]      drop_cnt;
`endif

    modport master (
        input  sync_pulse,
        input  evt_ready,
        input  ovf_clr,
        output evt_valid,
        output evt_ts,
        output evt_level,
`ifdef PULSE_EVT_DROP_CNT_EN
        output drop_cnt,
`endif
        output ovf
    );

    modport slave (
        output sync_pulse,
        output evt_ready,
        output ovf_clr,
        input  evt_valid,
        input  evt_ts,
        input  evt_level,
`ifdef PULSE_EVT_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  ovf
    );
endinterface

// File: rtl/pulse_evt_collector.sv
// pulse_evt_collector
// Turns each rising edge of a synchronised, stretched pulse into one event
// stamped with a free-running timestamp, buffers events in a show-ahead FIFO
// drained by valid/ready, and flags lost events with a sticky overflow bit.
// Ports:
//   clk              single clock, rising edge
//   rst              asynchronous, active-high reset
//   evt_bus.master   sync_pulse, evt_ready, ovf_clr in;
//                    evt_valid, evt_ts, evt_level, ovf out
// Build option:
//   PULSE_EVT_DROP_CNT_EN  adds evt_bus.drop_cnt, a saturating 8-bit count of
//                          dropped events cleared by ovf_clr.
module pulse_evt_collector #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    pulse_evt_if.master evt_bus
);

    localparam int unsigned PW = AW + 1;

    logic [TS_W-1:0] ts_cnt;
    logic            sync_d;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TS_W-1:0] mem [DEPTH];
    logic            ovf;

    logic            rise;
    logic            pop;
    logic            full;
    logic            push;
    logic            drop;
    logic [PW-1:0]   level;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // Rising-edge detect; sync_d resets low so a pulse held through reset counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_d <= 1'b0;
        end else begin
            sync_d <= evt_bus.sync_pulse;
        end
    end

    // FIFO control: a pop frees the slot the same cycle, so full+pop+rise is not a drop.
    always_comb begin
        rise  = evt_bus.sync_pulse & ~sync_d;
        level = wr_ptr - rd_ptr;
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = (level != '0) & evt_bus.evt_ready;
        push  = rise & (~full | pop);
        drop  = rise & full & ~pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is intentionally not reset; the read mux masks it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= ts_cnt;
        end
    end

    // Sticky overflow: a drop in the clear cycle keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (evt_bus.ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef PULSE_EVT_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturating drop counter; clear and drop together leave a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (evt_bus.ovf_clr) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign evt_bus.drop_cnt = drop_cnt;
`endif

    // Show-ahead outputs, all derived from registered state.
    assign evt_bus.evt_valid = (level != '0);
    assign evt_bus.evt_ts    = (level != '0) ? mem[rd_ptr[AW-1:0]] : '0;
    assign evt_bus.evt_level = level;
    assign evt_bus.ovf       = ovf;

endmodule

// File: tb/tb_pulse_evt_collector.sv
// Directed bench for pulse_evt_collector: a TS_W=16 instance for the FIFO,
// overflow and drain behaviour, and a TS_W=4 instance for timestamp wrap and
// mid-operation reset.
module tb_pulse_evt_collector;

    logic clk;
    logic rst;
    logic rst4;

    int n_cmp;
    int n_err;

    pulse_evt_if #(.TS_W(16), .AW(3)) bus  ();
    pulse_evt_if #(.TS_W(4),  .AW(3)) bus4 ();

    pulse_evt_collector #(.TS_W(16), .DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .evt_bus (bus)
    );

    pulse_evt_collector #(.TS_W(4), .DEPTH(8), .AW(3)) dut4 (
        .clk     (clk),
        .rst     (rst4),
        .evt_bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] exp_ts [8];

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.sync_pulse  = 1'b0;
        bus.evt_ready   = 1'b0;
        bus.ovf_clr     = 1'b0;
        bus4.sync_pulse = 1'b0;
        bus4.evt_ready  = 1'b0;
        bus4.ovf_clr    = 1'b0;
        rst  = 1'b1;
        rst4 = 1'b1;
        step(2);

        // Reset state
        chk("rst_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_level", 32'(bus.evt_level), 32'd0);
        chk("rst_ts",    32'(bus.evt_ts),    32'd0);
        chk("rst_ovf",   32'(bus.ovf),       32'd0);

        // Single pulse at ts=5: edges 0..4 idle, pulse sampled at edge 5
        rst = 1'b0;
        step(5);
        bus.sync_pulse = 1'b1;
        step(1);
        bus.sync_pulse = 1'b0;
        chk("single_valid", 32'(bus.evt_valid), 32'd1);
        chk("single_ts",    32'(bus.evt_ts),    32'd5);
        chk("single_level", 32'(bus.evt_level), 32'd1);
        bus.evt_ready = 1'b1;
        step(1);
        bus.evt_ready = 1'b0;
        chk("single_pop_level", 32'(bus.evt_level), 32'd0);
        chk("single_pop_ts",    32'(bus.evt_ts),    32'd0);

        // Empty with ready: ready alone does nothing, rise+ready pushes (no bypass)
        bus.evt_ready  = 1'b1;
        bus.sync_pulse = 1'b1;
        step(1);
        bus.evt_ready  = 1'b0;
        chk("empty_rise_ready_level", 32'(bus.evt_level), 32'd1);
        chk("empty_rise_ready_ts",    32'(bus.evt_ts),    32'd7);

        // Long pulse: held 20 cycles (already high one) -> still one event
        step(19);
        bus.sync_pulse = 1'b0;
        step(1);
        chk("long_level", 32'(bus.evt_level), 32'd1);
        bus.evt_ready = 1'b1;
        step(1);
        bus.evt_ready = 1'b0;
        chk("long_drained", 32'(bus.evt_valid), 32'd0);

        // Fill: 9 one-cycle pulses at ts 3,5,...,19; ninth is dropped
        rst = 1'b1;
        step(1);
        chk("rst2_level", 32'(bus.evt_level), 32'd0);
        rst = 1'b0;
        step(3);
        for (int i = 0; i < 9; i++) begin
            bus.sync_pulse = 1'b1;
            step(1);
            bus.sync_pulse = 1'b0;
            step(1);
            if (i == 7) begin
                chk("fill8_level", 32'(bus.evt_level), 32'd8);
                chk("fill8_ovf",   32'(bus.ovf),       32'd0);
            end
        end
        chk("ovf_level", 32'(bus.evt_level), 32'd8);
        chk("ovf_set",   32'(bus.ovf),       32'd1);
        chk("ovf_head",  32'(bus.evt_ts),    32'd3);
`ifdef PULSE_EVT_DROP_CNT_EN
        chk("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd1);
`endif

        // Clear coincident with a drop (edge 21): set wins
        bus.sync_pulse = 1'b1;
        bus.ovf_clr    = 1'b1;
        step(1);
        bus.sync_pulse = 1'b0;
        chk("clr_drop_ovf", 32'(bus.ovf), 32'd1);
`ifdef PULSE_EVT_DROP_CNT_EN
        chk("clr_drop_cnt", 32'(bus.drop_cnt), 32'd1);
`endif
        // Clear alone (edge 22)
        step(1);
        bus.ovf_clr = 1'b0;
        chk("clr_ovf", 32'(bus.ovf), 32'd0);
`ifdef PULSE_EVT_DROP_CNT_EN
        chk("clr_cnt", 32'(bus.drop_cnt), 32'd0);
`endif

        // Full + rise + pop at edge 23: head 3 leaves, 23 enters
        bus.sync_pulse = 1'b1;
        bus.evt_ready  = 1'b1;
        step(1);
        bus.sync_pulse = 1'b0;
        bus.evt_ready  = 1'b0;
        chk("fullpop_level", 32'(bus.evt_level), 32'd8);
        chk("fullpop_ovf",   32'(bus.ovf),       32'd0);
        chk("fullpop_head",  32'(bus.evt_ts),    32'd5);

        // Drain and check order, newest at tail
        exp_ts[0] = 16'd5;  exp_ts[1] = 16'd7;  exp_ts[2] = 16'd9;  exp_ts[3] = 16'd11;
        exp_ts[4] = 16'd13; exp_ts[5] = 16'd15; exp_ts[6] = 16'd17; exp_ts[7] = 16'd23;
        bus.evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_ts%0d", k), 32'(bus.evt_ts), 32'(exp_ts[k]));
            step(1);
        end
        bus.evt_ready = 1'b0;
        chk("drain_valid", 32'(bus.evt_valid), 32'd0);
        chk("drain_level", 32'(bus.evt_level), 32'd0);

        // TS_W=4: events at ts 15 and 2 (wrapped)
        rst4 = 1'b0;
        step(15);
        bus4.sync_pulse = 1'b1;
        step(1);
        bus4.sync_pulse = 1'b0;
        step(2);
        bus4.sync_pulse = 1'b1;
        step(1);
        bus4.sync_pulse = 1'b0;
        chk("wrap_level", 32'(bus4.evt_level), 32'd2);
        chk("wrap_ts0",   32'(bus4.evt_ts),    32'd15);
        bus4.evt_ready = 1'b1;
        step(1);
        bus4.evt_ready = 1'b0;
        chk("wrap_ts1",   32'(bus4.evt_ts),    32'd2);

        // More events, then asynchronous reset mid-burst with pulse held high
        bus4.sync_pulse = 1'b1;
        step(2);
        bus4.sync_pulse = 1'b0;
        step(1);
        bus4.sync_pulse = 1'b1;
        step(1);
        chk("burst_level", 32'(bus4.evt_level), 32'd3);
        #2;
        rst4 = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus4.evt_valid), 32'd0);
        chk("midrst_level", 32'(bus4.evt_level), 32'd0);
        step(1);
        rst4 = 1'b0;
        step(1);
        chk("relhi_level", 32'(bus4.evt_level), 32'd1);
        chk("relhi_ts",    32'(bus4.evt_ts),    32'd0);
        bus4.sync_pulse = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
